// File: rtl/sik_isa_pkg.sv
// Shared SIK instruction-set constants: opcodes, reject codes and the encoder FSM states.
// Imported by the program encoder, its word packer and the fetch-side decoder.
package sik_isa_pkg;

   // Normal opcodes (upper nibble of a word); 0 selects the NOARG group.
   localparam logic [3:0] NOARG    = 4'h0;
   localparam logic [3:0] OP_GET   = 4'h1;
   localparam logic [3:0] OP_POP   = 4'h2;
   localparam logic [3:0] OP_PUT   = 4'h3;
   localparam logic [3:0] OP_CALL  = 4'h4;
   localparam logic [3:0] OP_JUMPF = 4'h5;
   localparam logic [3:0] OP_JUMP  = 4'h6;
   localparam logic [3:0] OP_JUMPT = 4'h7;
   localparam logic [3:0] OP_PUSH  = 4'h8;
   localparam logic [3:0] OP_PRE   = 4'hF;

   // Extended opcodes live in the low nibble of a NOARG word.
   localparam logic [3:0] XOP_ADD   = 4'h1;
   localparam logic [3:0] XOP_LT    = 4'h2;
   localparam logic [3:0] XOP_SUB   = 4'h3;
   localparam logic [3:0] XOP_AND   = 4'h4;
   localparam logic [3:0] XOP_OR    = 4'h5;
   localparam logic [3:0] XOP_XOR   = 4'h6;
   localparam logic [3:0] XOP_DUP   = 4'h7;
   localparam logic [3:0] XOP_RET   = 4'h8;
   localparam logic [3:0] XOP_SYS   = 4'h9;
   localparam logic [3:0] XOP_LOAD  = 4'hA;
   localparam logic [3:0] XOP_STORE = 4'hB;
   localparam logic [3:0] XOP_TEST  = 4'hC;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_BADOP    = 2'd1;
   localparam logic [1:0] ERR_IMMRANGE = 2'd2;
   localparam logic [1:0] ERR_FULL     = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_INSN = 2'd2
   } enc_state_e;

   function automatic logic [15:0] make_pre_word(input logic [3:0] immed_hi);
      return {OP_PRE, 8'h00, immed_hi};
   endfunction

endpackage

// File: rtl/sik_word_pack.sv
// Combinational SIK word builder: instruction word, optional PRE prefix word,
// word count and opcode/immediate validity for one symbolic instruction.
module sik_word_pack
   import sik_isa_pkg::*;
(
   input  logic        ext_i,
   input  logic [3:0]  op_i,
   input  logic [15:0] immed_i,
   output logic [15:0] insn_word_o,
   output logic [15:0] pre_word_o,
   output logic        need_pre_o,
   output logic [1:0]  n_words_o,
   output logic [1:0]  code_o
);

   logic immed_hi_nz;

   always_comb begin
      immed_hi_nz = (immed_i[15:12] != 4'h0);
      insn_word_o = ext_i ? {NOARG, 8'h00, op_i} : {op_i, immed_i[11:0]};
      pre_word_o  = make_pre_word(immed_i[15:12]);
      need_pre_o  = 1'b0;
      code_o      = ERR_NONE;

      if (ext_i) begin
         if ((op_i < XOP_ADD) || (op_i > XOP_TEST)) begin
            code_o = ERR_BADOP;
         end
      end else if ((op_i < OP_GET) || (op_i > OP_PUSH)) begin
         // PRE is only ever generated here, never accepted as an input op.
         code_o = ERR_BADOP;
      end else if (op_i <= OP_PUT) begin
         if (immed_hi_nz) begin
            code_o = ERR_IMMRANGE;
         end
      end else begin
         need_pre_o = immed_hi_nz;
      end

      n_words_o = need_pre_o ? 2'd2 : 2'd1;
   end

endmodule

// File: rtl/sik_program_encoder.sv
// Encodes symbolic SIK instructions into 16-bit words and writes them into the
// interleaved two-thread instruction memory (thread 0 even, thread 1 odd addresses).
module sik_program_encoder
   import sik_isa_pkg::*;
#(
   parameter int MEM_AW = 16,
   parameter int BASE0  = 0,
   parameter int BASE1  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_thread,
   input  logic              in_ext,
   input  logic [3:0]        in_op,
   input  logic [15:0]       in_immed,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [15:0]       mem_data,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [MEM_AW-1:0] count0,
   output logic [MEM_AW-1:0] count1
);

   localparam logic [MEM_AW-1:0] BASE0_A = MEM_AW'(BASE0);
   localparam logic [MEM_AW-1:0] BASE1_A = MEM_AW'(BASE1);
   localparam logic [MEM_AW-1:0] STEP    = MEM_AW'(2);
   localparam logic [MEM_AW-1:0] ONE     = MEM_AW'(1);
   // Each thread owns half of the address space.
   localparam logic [MEM_AW:0]   SLOTS   = {2'b01, {(MEM_AW-1){1'b0}}};

   enc_state_e        state_q;
   logic              thread_q;
   logic              ext_q;
   logic [3:0]        op_q;
   logic [15:0]       immed_q;
   logic [MEM_AW-1:0] ptr0_q, ptr1_q;
   logic [MEM_AW-1:0] count0_q, count1_q;
   logic              mem_we_q;
   logic [MEM_AW-1:0] mem_addr_q;
   logic [15:0]       mem_data_q;
   logic              err_q;
   logic [1:0]        err_code_q;

   logic [MEM_AW-1:0] ptr0_d, ptr1_d;
   logic [MEM_AW-1:0] cur_ptr, cur_cnt;
   logic [MEM_AW:0]   free_slots, need_slots;
   logic [1:0]        rej_code;

   logic              pk_ext;
   logic [3:0]        pk_op;
   logic [15:0]       pk_immed;
   logic [15:0]       pk_insn_word;
   logic [15:0]       pk_pre_word;
   logic              pk_need_pre;
   logic [1:0]        pk_n_words;
   logic [1:0]        pk_code;

   // The packer looks at the live offer while idle and at the latched copy afterwards.
   always_comb begin
      pk_ext   = (state_q == ST_IDLE) ? in_ext   : ext_q;
      pk_op    = (state_q == ST_IDLE) ? in_op    : op_q;
      pk_immed = (state_q == ST_IDLE) ? in_immed : immed_q;
   end

   sik_word_pack u_word_pack (
      .ext_i       (pk_ext),
      .op_i        (pk_op),
      .immed_i     (pk_immed),
      .insn_word_o (pk_insn_word),
      .pre_word_o  (pk_pre_word),
      .need_pre_o  (pk_need_pre),
      .n_words_o   (pk_n_words),
      .code_o      (pk_code)
   );

   always_comb begin
      ptr0_d     = ptr0_q + STEP;
      ptr1_d     = ptr1_q + STEP;
      cur_ptr    = in_thread ? ptr1_q : ptr0_q;
      cur_cnt    = in_thread ? count1_q : count0_q;
      free_slots = SLOTS - {1'b0, cur_cnt};
      need_slots = {{(MEM_AW-1){1'b0}}, pk_n_words};
      rej_code   = pk_code;
      if ((pk_code == ERR_NONE) && (free_slots < need_slots)) begin
         rej_code = ERR_FULL;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         thread_q   <= 1'b0;
         ext_q      <= 1'b0;
         op_q       <= 4'h0;
         immed_q    <= 16'h0000;
         ptr0_q     <= BASE0_A;
         ptr1_q     <= BASE1_A;
         count0_q   <= '0;
         count1_q   <= '0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= 16'h0000;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         err_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  if (rej_code != ERR_NONE) begin
                     err_q      <= 1'b1;
                     err_code_q <= rej_code;
                  end else begin
                     thread_q   <= in_thread;
                     ext_q      <= in_ext;
                     op_q       <= in_op;
                     immed_q    <= in_immed;
                     mem_we_q   <= 1'b1;
                     mem_addr_q <= cur_ptr;
                     mem_data_q <= pk_need_pre ? pk_pre_word : pk_insn_word;
                     state_q    <= pk_need_pre ? ST_PRE : ST_INSN;
                  end
               end
            end
            ST_PRE: begin
               // Prefix is on the bus this cycle; queue the instruction word at the next slot.
               if (thread_q) begin
                  ptr1_q     <= ptr1_d;
                  count1_q   <= count1_q + ONE;
                  mem_addr_q <= ptr1_d;
               end else begin
                  ptr0_q     <= ptr0_d;
                  count0_q   <= count0_q + ONE;
                  mem_addr_q <= ptr0_d;
               end
               mem_we_q   <= 1'b1;
               mem_data_q <= pk_insn_word;
               state_q    <= ST_INSN;
            end
            ST_INSN: begin
               if (thread_q) begin
                  ptr1_q   <= ptr1_d;
                  count1_q <= count1_q + ONE;
               end else begin
                  ptr0_q   <= ptr0_d;
                  count0_q <= count0_q + ONE;
               end
               mem_we_q <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: begin
               mem_we_q <= 1'b0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready = (state_q == ST_IDLE);
   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign err      = err_q;
   assign err_code = err_code_q;
   assign count0   = count0_q;
   assign count1   = count1_q;

endmodule

// File: tb/tb_sik_program_encoder.sv
// Bench for sik_program_encoder: directed vector tables, reset-abort and fill-to-full
// sequences, and randomized instructions checked against a slot-arithmetic model.
module tb_sik_program_encoder;

   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_thread = 1'b0;
   logic          in_ext = 1'b0;
   logic [3:0]    in_op = 4'h0;
   logic [15:0]   in_immed = 16'h0000;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_data;
   logic          err;
   logic [1:0]    err_code;
   logic [AW-1:0] count0, count1;

   int n_cmp = 0;
   int n_bad = 0;
   int mcnt[2];
   logic [31:0] exp_q[$];

   typedef struct {
      logic        rst;
      logic        thr;
      logic        ext;
      logic [3:0]  op;
      logic [15:0] imm;
      logic [1:0]  code;
      int          nw;
      logic [15:0] a0, d0, a1, d1;
   } vec_t;

   vec_t tbl[13];
   vec_t tail[5];

   sik_program_encoder #(.MEM_AW(AW), .BASE0(0), .BASE1(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_thread (in_thread),
      .in_ext    (in_ext),
      .in_op     (in_op),
      .in_immed  (in_immed),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .err       (err),
      .err_code  (err_code),
      .count0    (count0),
      .count1    (count1)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Write monitor: every strobed cycle must match the next expected {addr, data}.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %h data %h, expected no write (t=%0t)",
                     mem_addr, mem_data, $time);
         end else begin
            check("write", {mem_addr, mem_data}, exp_q.pop_front());
         end
      end
   end

   // Reference: validity from the opcode tables, words from slot arithmetic.
   task automatic model(input logic thr, input logic ext, input logic [3:0] op,
                        input logic [15:0] imm, output logic [1:0] code, output int nw);
      int op_n, hi, free;
      op_n = int'(op);
      hi   = int'(imm) / 4096;
      free = 32768 - mcnt[thr];
      code = 2'd0;
      nw   = 0;
      if (ext ? (op_n < 1 || op_n > 12) : (op_n < 1 || op_n > 8)) code = 2'd1;
      else if (!ext && op_n <= 3 && hi != 0) code = 2'd2;
      else begin
         nw = (!ext && hi != 0) ? 2 : 1;
         if (free < nw) begin
            code = 2'd3;
            nw   = 0;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      mcnt[0] = 0;
      mcnt[1] = 0;
      check("rst_in_ready", in_ready, 1);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_data", mem_data, 0);
      check("rst_err", err, 0);
      check("rst_err_code", err_code, 0);
      check("rst_count0", count0, 0);
      check("rst_count1", count1, 0);
   endtask

   // Offer one instruction (entered and left at posedge+1) and check its outcome.
   task automatic run_insn(input logic thr, input logic ext, input logic [3:0] op,
                           input logic [15:0] imm, input logic [1:0] ecode, input int enw,
                           input logic [31:0] last);
      int w, busy;
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin
         @(posedge clk);
         #1 w++;
      end
      if (in_ready !== 1'b1) check("ready_timeout", 0, 1);
      in_valid = 1'b1;
      in_thread = thr;
      in_ext = ext;
      in_op = op;
      in_immed = imm;
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("err", err, (ecode != 2'd0) ? 1 : 0);
      if (ecode != 2'd0) check("err_code", err_code, ecode);
      busy = 0;
      while (in_ready !== 1'b1 && busy < 20) begin
         @(posedge clk);
         #1 busy++;
      end
      check("busy_cycles", busy, enw);
      mcnt[thr] += enw;
      check("count0", count0, mcnt[0]);
      check("count1", count1, mcnt[1]);
      if (enw > 0) begin
         check("hold_addr", mem_addr, last[31:16]);
         check("hold_data", mem_data, last[15:0]);
      end else begin
         @(posedge clk);
         #1 check("err_pulse", err, 0);
      end
   endtask

   task automatic apply_vec(input vec_t v);
      logic [31:0] last;
      if (v.rst) do_reset();
      last = 32'h0;
      if (v.nw >= 1) begin
         exp_q.push_back({v.a0, v.d0});
         last = {v.a0, v.d0};
      end
      if (v.nw == 2) begin
         exp_q.push_back({v.a1, v.d1});
         last = {v.a1, v.d1};
      end
      run_insn(v.thr, v.ext, v.op, v.imm, v.code, v.nw, last);
   endtask

   task automatic send_model(input logic thr, input logic ext, input logic [3:0] op,
                             input logic [15:0] imm);
      logic [1:0]  code;
      int          nw;
      logic [15:0] addr, word;
      logic [31:0] last;
      model(thr, ext, op, imm, code, nw);
      addr = 16'(int'(thr) + 2 * mcnt[thr]);
      last = 32'h0;
      if (nw == 2) begin
         exp_q.push_back({addr, 16'hF000 + 16'(int'(imm) / 4096)});
         addr = addr + 16'd2;
      end
      if (nw >= 1) begin
         word = ext ? 16'(int'(op)) : 16'(int'(op) * 4096 + int'(imm) % 4096);
         exp_q.push_back({addr, word});
         last = {addr, word};
      end
      run_insn(thr, ext, op, imm, code, nw, last);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'h8, 16'h0042, 2'd0, 1, 16'h0000, 16'h8042, 16'h0, 16'h0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'h6, 16'h3123, 2'd0, 2, 16'h0001, 16'hF003, 16'h0003, 16'h6123};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 4'h1, 16'h0000, 2'd0, 1, 16'h0000, 16'h0001, 16'h0, 16'h0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'h9, 16'hFFFF, 2'd0, 1, 16'h0002, 16'h0009, 16'h0, 16'h0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'h1, 16'h1005, 2'd2, 0, 16'h0, 16'h0, 16'h0, 16'h0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 4'hD, 16'h0000, 2'd1, 0, 16'h0, 16'h0, 16'h0, 16'h0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 2'd1, 0, 16'h0, 16'h0, 16'h0, 16'h0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'hF, 16'h0123, 2'd1, 0, 16'h0, 16'h0, 16'h0, 16'h0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 4'h9, 16'h0000, 2'd1, 0, 16'h0, 16'h0, 16'h0, 16'h0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 4'h3, 16'h0FFF, 2'd0, 1, 16'h0001, 16'h3FFF, 16'h0, 16'h0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 4'h4, 16'hF000, 2'd0, 2, 16'h0004, 16'hF00F, 16'h0006, 16'h4000};
      tbl[11] = '{1'b0, 1'b1, 1'b1, 4'hC, 16'h1234, 2'd0, 1, 16'h0003, 16'h000C, 16'h0, 16'h0};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 4'h0, 16'h0000, 2'd1, 0, 16'h0, 16'h0, 16'h0, 16'h0};

      // Thread 0 holds 32767 words when these are applied.
      tail[0] = '{1'b0, 1'b0, 1'b0, 4'h6, 16'h1234, 2'd3, 0, 16'h0, 16'h0, 16'h0, 16'h0};
      tail[1] = '{1'b0, 1'b0, 1'b0, 4'h8, 16'h0005, 2'd0, 1, 16'hFFFE, 16'h8005, 16'h0, 16'h0};
      tail[2] = '{1'b0, 1'b0, 1'b0, 4'h8, 16'h0006, 2'd3, 0, 16'h0, 16'h0, 16'h0, 16'h0};
      tail[3] = '{1'b0, 1'b0, 1'b1, 4'h1, 16'h0000, 2'd3, 0, 16'h0, 16'h0, 16'h0, 16'h0};
      tail[4] = '{1'b0, 1'b1, 1'b0, 4'h8, 16'h0007, 2'd0, 1, 16'h0001, 16'h8007, 16'h0, 16'h0};

      mcnt[0] = 0;
      mcnt[1] = 0;

      for (int i = 0; i < 13; i++) apply_vec(tbl[i]);

      // Reset in the PRE cycle of a 2-word call: prefix was on the bus, instruction word never is.
      do_reset();
      exp_q.push_back({16'h0000, 16'hF002});
      in_valid = 1'b1;
      in_thread = 1'b0;
      in_ext = 1'b0;
      in_op = 4'h4;
      in_immed = 16'h2ABC;
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("abort_pre_we", mem_we, 1);
      check("abort_pre_data", mem_data, 16'hF002);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      mcnt[0] = 0;
      mcnt[1] = 0;
      for (int i = 0; i < 3; i++) begin
         check("abort_no_we", mem_we, 0);
         @(posedge clk);
         #1;
      end
      check("abort_count0", count0, 0);
      check("abort_count1", count1, 0);
      check("abort_ready", in_ready, 1);
      exp_q.push_back({16'h0000, 16'h8001});
      run_insn(1'b0, 1'b0, 4'h8, 16'h0001, 2'd0, 1, {16'h0000, 16'h8001});
      exp_q.push_back({16'h0001, 16'h8002});
      run_insn(1'b1, 1'b0, 4'h8, 16'h0002, 2'd0, 1, {16'h0001, 16'h8002});

      // Randomized instruction mix against the model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic        r_thr, r_ext;
         logic [3:0]  r_op;
         logic [15:0] r_imm;
         r_thr = 1'($urandom_range(0, 1));
         r_ext = ($urandom_range(0, 3) == 0);
         r_op  = 4'($urandom_range(0, 15));
         r_imm = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 4095)) : 16'($urandom);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         send_model(r_thr, r_ext, r_op, r_imm);
      end

      // Fill thread 0 to one free slot, then probe the FULL boundary.
      do_reset();
      for (int i = 0; i < 16383; i++) send_model(1'b0, 1'b0, 4'h4, 16'h1000);
      send_model(1'b0, 1'b0, 4'h8, 16'h0000);
      check("fill_count0", count0, 32767);
      for (int i = 0; i < 5; i++) apply_vec(tail[i]);

      repeat (3) @(posedge clk);
      #1 check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
